// File: rtl/display_scan_ctrl_if.sv
// Datapath-side and pin-side signals of the 7-segment scan controller.
// The master drives digits and controls; the slave (controller) drives the pins.
interface display_scan_ctrl_if #(
   parameter int N_DIG   = 4,
   parameter int PRESC_W = 16
);
   logic                 i_En;
   logic [PRESC_W-1:0]   i_Presc;
   logic [4*N_DIG-1:0]   i_Data;
   logic [N_DIG-1:0]     i_Dp;
   logic                 i_LzbEn;
   logic [N_DIG-1:0]     o_An;
   logic [6:0]           o_Seg;
   logic                 o_Dp;
   logic                 o_Frame;

   modport master (
      output i_En, i_Presc, i_Data, i_Dp, i_LzbEn,
      input  o_An, o_Seg, o_Dp, o_Frame
   );

   modport slave (
      input  i_En, i_Presc, i_Data, i_Dp, i_LzbEn,
      output o_An, o_Seg, o_Dp, o_Frame
   );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner: blank gap, per-digit dwell,
// hex decode, leading-zero blanking and a frame-end pulse. All outputs registered.
module display_scan_ctrl #(
   parameter int N_DIG     = 4,
   parameter int PRESC_W   = 16,
   parameter int BLANK_CYC = 8
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   display_scan_ctrl_if.slave bus
);
   localparam int                 IDX_W      = $clog2(N_DIG);
   localparam logic [PRESC_W-1:0] BLANK_LAST = PRESC_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIG - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                      state, state_nxt;
   logic [IDX_W-1:0]            idx, idx_nxt;
   logic [PRESC_W-1:0]          timer, timer_nxt;
   logic [PRESC_W-1:0]          dwell, dwell_nxt;
   logic [N_DIG-1:0][3:0]       snap_data, snap_data_nxt;
   logic [N_DIG-1:0]            snap_dp, snap_dp_nxt;
   logic [N_DIG-1:0]            an, an_nxt, show_an;
   logic [6:0]                  seg, seg_nxt, show_seg;
   logic                        dp, dp_nxt, show_dp;
   logic                        frame, frame_nxt;
   logic [N_DIG-1:0]            hi_zero;
   logic                        zacc;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   // hi_zero[k]: snapshot digits k..N_DIG-1 are all zero
   always_comb begin
      hi_zero = '0;
      zacc    = 1'b1;
      for (int k = N_DIG - 1; k >= 0; k--) begin
         zacc       = zacc && (snap_data[k] == 4'h0);
         hi_zero[k] = zacc;
      end
   end

   // Pin values for the current digit; blanking enable is taken live every cycle
   always_comb begin
      show_an      = '1;
      show_an[idx] = 1'b0;
      show_seg     = (bus.i_LzbEn && idx != '0 && hi_zero[idx]) ? 7'h7F : hex7(snap_data[idx]);
      show_dp      = ~snap_dp[idx];
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      timer_nxt     = timer;
      dwell_nxt     = dwell;
      snap_data_nxt = snap_data;
      snap_dp_nxt   = snap_dp;
      an_nxt        = '1;
      seg_nxt       = 7'h7F;
      dp_nxt        = 1'b1;
      frame_nxt     = 1'b0;
      if (!bus.i_En) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         timer_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               snap_data_nxt = bus.i_Data;
               snap_dp_nxt   = bus.i_Dp;
               idx_nxt       = '0;
               timer_nxt     = '0;
               state_nxt     = BLANK;
            end
            BLANK: begin
               if (timer == BLANK_LAST) begin
                  dwell_nxt = (bus.i_Presc == '0) ? PRESC_W'(1) : bus.i_Presc;
                  timer_nxt = '0;
                  state_nxt = SHOW;
                  an_nxt    = show_an;
                  seg_nxt   = show_seg;
                  dp_nxt    = show_dp;
               end else begin
                  timer_nxt = timer + PRESC_W'(1);
               end
            end
            SHOW: begin
               if (timer == dwell - PRESC_W'(1)) begin
                  timer_nxt = '0;
                  state_nxt = BLANK;
                  if (idx == IDX_LAST) begin
                     // frame boundary: fresh snapshot so a frame never tears
                     idx_nxt       = '0;
                     snap_data_nxt = bus.i_Data;
                     snap_dp_nxt   = bus.i_Dp;
                     frame_nxt     = 1'b1;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end else begin
                  timer_nxt = timer + PRESC_W'(1);
                  an_nxt    = show_an;
                  seg_nxt   = show_seg;
                  dp_nxt    = show_dp;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state     <= IDLE;
         idx       <= '0;
         timer     <= '0;
         dwell     <= '0;
         snap_data <= '0;
         snap_dp   <= '0;
         an        <= '1;
         seg       <= 7'h7F;
         dp        <= 1'b1;
         frame     <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         timer     <= timer_nxt;
         dwell     <= dwell_nxt;
         snap_data <= snap_data_nxt;
         snap_dp   <= snap_dp_nxt;
         an        <= an_nxt;
         seg       <= seg_nxt;
         dp        <= dp_nxt;
         frame     <= frame_nxt;
      end
   end

   assign bus.o_An    = an;
   assign bus.o_Seg   = seg;
   assign bus.o_Dp    = dp;
   assign bus.o_Frame = frame;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a queue-based schedule model predicts every pin cycle.
module tb_display_scan_ctrl;
   localparam int N   = 4;
   localparam int PW  = 16;
   localparam int BLK = 2;
   localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec = 0;
   int   err = 0;

   display_scan_ctrl_if #(.N_DIG(N), .PRESC_W(PW)) bus();

   display_scan_ctrl #(.N_DIG(N), .PRESC_W(PW), .BLANK_CYC(BLK)) dut (
      .i_Clk(clk), .i_Rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic [12:0] got, want;
   assign got = {bus.o_An, bus.o_Seg, bus.o_Dp, bus.o_Frame};

   // Model: a frame is a list of chunks (blank gap, then dwell of one digit), one entry per clock.
   int          q_dig[$];
   bit          q_frm[$];
   int          cur_dig;
   bit          in_blank, active;
   logic [15:0] m_data;
   logic [3:0]  m_dp;

   always @(posedge clk or negedge rst) begin : mdl
      int d, n;
      bit f;
      logic [3:0] an;
      logic [6:0] sg;
      if (!rst || !bus.i_En) begin
         q_dig.delete(); q_frm.delete();
         active = 0;
         want   = DARK;
      end else begin
         if (!active) begin
            active = 1; cur_dig = 0; m_data = bus.i_Data; m_dp = bus.i_Dp;
            for (int i = 0; i < BLK; i++) begin q_dig.push_back(-1); q_frm.push_back(0); end
            in_blank = 1;
         end else if (q_dig.size() == 0) begin
            if (in_blank) begin
               n = (bus.i_Presc == 0) ? 1 : int'(bus.i_Presc);
               for (int i = 0; i < n; i++) begin q_dig.push_back(cur_dig); q_frm.push_back(0); end
               in_blank = 0;
            end else begin
               f = 0;
               if (cur_dig == N - 1) begin
                  cur_dig = 0; m_data = bus.i_Data; m_dp = bus.i_Dp; f = 1;
               end else cur_dig++;
               for (int i = 0; i < BLK; i++) begin q_dig.push_back(-1); q_frm.push_back(f && i == 0); end
               in_blank = 1;
            end
         end
         d = q_dig.pop_front();
         f = q_frm.pop_front();
         if (d < 0) want = {4'hF, 7'h7F, 1'b1, f};
         else begin
            an = 4'hF; an[d] = 1'b0;
            sg = dec[(m_data >> (4 * d)) & 16'hF];
            if (bus.i_LzbEn && d > 0 && (m_data >> (4 * d)) == 0) sg = 7'h7F;
            want = {an, sg, ~m_dp[d], 1'b0};
         end
      end
   end

   task automatic test_reset;
      repeat (3) begin
         @(negedge clk); vec++;
         if (got !== DARK) begin err++; $display("FAIL reset got=%h want=%h", got, DARK); end
      end
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL idle got=%h want=%h", got, want); end
      end
   endtask

   task automatic test_enable;
      int last_f = -1;
      bus.i_Data = 16'h1234; bus.i_Presc = 5; bus.i_En = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL enable t=%0t got=%h want=%h", $time, got, want); end
         if (bus.o_Frame) begin
            if (last_f >= 0) begin
               vec++;
               if (c - last_f != 28) begin err++; $display("FAIL frame_period got=%0d want=28", c - last_f); end
            end
            last_f = c;
         end
      end
   endtask

   task automatic test_mid_frame;
      bit hit = 0;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL midframe_wait got=%h want=%h", got, want); end
         hit = (bus.o_An == 4'b1101);
      end
      vec++;
      if (!hit) begin err++; $display("FAIL midframe_timeout got=0 want=1"); end
      bus.i_Data = 16'h5678;
      repeat (70) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL midframe t=%0t got=%h want=%h", $time, got, want); end
      end
   endtask

   task automatic test_lzb;
      bus.i_Data = 16'h0030; bus.i_LzbEn = 1'b1; bus.i_Dp = 4'b1000;
      repeat (70) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL lzb_0030 t=%0t got=%h want=%h", $time, got, want); end
      end
      bus.i_Data = 16'h0000;
      repeat (70) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL lzb_0000 t=%0t got=%h want=%h", $time, got, want); end
      end
      bus.i_LzbEn = 1'b0; bus.i_Dp = 4'b0000; bus.i_Data = 16'h1234;
   endtask

   task automatic test_dwell;
      bit hit = 0;
      bus.i_Presc = 0;
      repeat (40) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL presc0 t=%0t got=%h want=%h", $time, got, want); end
      end
      bus.i_Presc = 5;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL presc_wait got=%h want=%h", got, want); end
         hit = (bus.o_An == 4'b1110) && (want[12:9] == 4'b1110);
      end
      @(negedge clk); vec++;
      if (got !== want) begin err++; $display("FAIL presc_mid got=%h want=%h", got, want); end
      bus.i_Presc = 3;
      repeat (50) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL presc_chg t=%0t got=%h want=%h", $time, got, want); end
      end
      bus.i_Presc = 5;
   endtask

   task automatic test_disable_reset;
      bit hit = 0;
      for (int c = 0; c < 80 && !hit; c++) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL dis_wait got=%h want=%h", got, want); end
         hit = (bus.o_An == 4'b1011);
      end
      bus.i_En = 1'b0;
      @(negedge clk); vec++;
      if (got !== DARK) begin err++; $display("FAIL disable got=%h want=%h", got, DARK); end
      repeat (2) @(negedge clk);
      bus.i_En = 1'b1;
      repeat (30) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL reenable t=%0t got=%h want=%h", $time, got, want); end
      end
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         @(negedge clk);
         hit = (bus.o_An != 4'hF);
      end
      #2 rst = 1'b0;
      #1 vec++;
      if (got !== DARK) begin err++; $display("FAIL async_rst got=%h want=%h", got, DARK); end
      @(negedge clk); rst = 1'b1;
      repeat (40) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL post_rst t=%0t got=%h want=%h", $time, got, want); end
      end
   endtask

   task automatic test_hex_sweep;
      bus.i_Presc = 5; bus.i_LzbEn = 1'b0;
      for (int v = 0; v < 16; v++) begin
         bus.i_Data = {16'($urandom_range(0, 4095)), 4'(v)};
         bus.i_Dp   = 4'($urandom);
         repeat (30) begin
            @(negedge clk); vec++;
            if (got !== want) begin err++; $display("FAIL hex_%0d t=%0t got=%h want=%h", v, $time, got, want); end
         end
      end
   endtask

   task automatic test_random;
      logic [15:0] d;
      repeat (1500) begin
         @(negedge clk); vec++;
         if (got !== want) begin err++; $display("FAIL random t=%0t got=%h want=%h", $time, got, want); end
         if ($urandom_range(0, 19) == 0) begin
            for (int k = 0; k < 4; k++) d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus.i_Data = d;
         end
         if ($urandom_range(0, 19) == 0) bus.i_Dp = 4'($urandom);
         if ($urandom_range(0, 29) == 0) bus.i_LzbEn = ~bus.i_LzbEn;
         if ($urandom_range(0, 24) == 0) bus.i_Presc = 16'($urandom_range(0, 4));
         if (bus.i_En ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0)) bus.i_En = ~bus.i_En;
      end
   endtask

   initial begin
      bus.i_En = 1'b0; bus.i_Presc = 5; bus.i_Data = '0; bus.i_Dp = '0; bus.i_LzbEn = 1'b0;
      test_reset;
      test_enable;
      test_mid_frame;
      test_lzb;
      test_dwell;
      test_disable_reset;
      test_hex_sweep;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
